// File: rtl/seq_exec_pkg.sv
// Shared types for the sequence executor: sequence modes and controller states.
package seq_exec_pkg;

  typedef enum logic [1:0] {
    MODE_FIB   = 2'b00,
    MODE_ARITH = 2'b01,
    MODE_DBL   = 2'b10,
    MODE_DOWN  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_exec_alu.sv
// Combinational next-term generator: advances RA/RB for the selected mode and
// flags when the next emitted value would not fit in BITS.
module seq_exec_alu
  import seq_exec_pkg::*;
#(
  parameter int BITS = 8
) (
  input  mode_e             mode_i,
  input  logic [BITS-1:0]   ra_i,
  input  logic [BITS:0]     rb_i,
  output logic [BITS-1:0]   ra_next_o,
  output logic [BITS:0]     rb_next_o,
  output logic              carry_o
);

  logic [BITS:0] sum_s;
  logic [BITS:0] dbl_s;
  logic [BITS:0] diff_s;

  assign sum_s  = {1'b0, ra_i} + {1'b0, rb_i[BITS-1:0]};
  assign dbl_s  = {1'b0, ra_i} + {1'b0, ra_i};
  assign diff_s = {1'b0, ra_i} - {1'b0, rb_i[BITS-1:0]};

  always_comb begin
    ra_next_o = ra_i;
    rb_next_o = rb_i;
    carry_o   = 1'b0;
    case (mode_i)
      // Fibonacci: the next term is already sitting in RB, carry bit included.
      MODE_FIB: begin
        ra_next_o = rb_i[BITS-1:0];
        rb_next_o = {1'b0, ra_i} + rb_i;
        carry_o   = rb_i[BITS];
      end
      MODE_ARITH: begin
        ra_next_o = sum_s[BITS-1:0];
        carry_o   = sum_s[BITS];
      end
      MODE_DBL: begin
        ra_next_o = dbl_s[BITS-1:0];
        carry_o   = dbl_s[BITS];
      end
      MODE_DOWN: begin
        ra_next_o = diff_s[BITS-1:0];
        carry_o   = diff_s[BITS];
      end
      default: begin
        ra_next_o = ra_i;
        rb_next_o = rb_i;
        carry_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/sequence_executor.sv
// Sequence generator: on start, emits up to n_terms terms of the chosen
// sequence, one per non-stalled cycle, stopping early on carry/borrow.
module sequence_executor
  import seq_exec_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [BITS-1:0]   seed_a,
  input  logic [BITS-1:0]   seed_b,
  input  logic [CNT_W-1:0]  n_terms,
  input  logic              hold,
  input  logic              abort,
  output logic [BITS-1:0]   Ro,
  output logic              term_valid,
  output logic [CNT_W-1:0]  term_idx,
  output logic              busy,
  output logic              done,
  output logic              ovf
);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BITS-1:0]    ra_q, ra_d;
  logic [BITS:0]      rb_q, rb_d;
  logic [BITS-1:0]    ro_q, ro_d;
  logic               tv_q, tv_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

  logic [BITS-1:0]    ra_nxt;
  logic [BITS:0]      rb_nxt;
  logic               carry;

  seq_exec_alu #(.BITS(BITS)) u_alu (
    .mode_i    (mode_q),
    .ra_i      (ra_q),
    .rb_i      (rb_q),
    .ra_next_o (ra_nxt),
    .rb_next_o (rb_nxt),
    .carry_o   (carry)
  );

  // The term on Ro is always RA; the start cycle emits term 0 directly so the
  // first term_valid lands in the cycle right after start is sampled.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    n_d     = n_q;
    count_d = count_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    ro_d    = ro_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    tv_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          n_d     = n_terms;
          ra_d    = seed_a;
          rb_d    = {1'b0, seed_b};
          count_d = {CNT_W{1'b0}};
          ovf_d   = 1'b0;
          if (n_terms == {CNT_W{1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            ro_d    = seed_a;
            idx_d   = {CNT_W{1'b0}};
            tv_d    = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (hold) begin
          state_d = ST_RUN;
        end else if (carry || (count_q == n_q - CNT_W'(1))) begin
          state_d = ST_DONE;
          ovf_d   = carry;
        end else begin
          ra_d    = ra_nxt;
          rb_d    = rb_nxt;
          ro_d    = ra_nxt;
          count_d = count_q + CNT_W'(1);
          idx_d   = count_q + CNT_W'(1);
          tv_d    = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_FIB;
      n_q     <= {CNT_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
      ra_q    <= {BITS{1'b0}};
      rb_q    <= {(BITS+1){1'b0}};
      ro_q    <= {BITS{1'b0}};
      tv_q    <= 1'b0;
      idx_q   <= {CNT_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      n_q     <= n_d;
      count_q <= count_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      ro_q    <= ro_d;
      tv_q    <= tv_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Ro         = ro_q;
  assign term_valid = tv_q;
  assign term_idx   = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_sequence_executor.sv
// Randomized self-checking bench for sequence_executor against a queue-based
// model that lists each run's terms and overflow outcome with plain integers.
module tb_sequence_executor;

  localparam int BITS  = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       mode;
  logic [BITS-1:0]  seed_a;
  logic [BITS-1:0]  seed_b;
  logic [CNT_W-1:0] n_terms;
  logic             hold;
  logic             abort;
  logic [BITS-1:0]  Ro;
  logic             term_valid;
  logic [CNT_W-1:0] term_idx;
  logic             busy;
  logic             done;
  logic             ovf;

  int checks   = 0;
  int failures = 0;
  int exp_q[$];
  bit exp_ovf;

  sequence_executor #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .seed_a(seed_a),
    .seed_b(seed_b), .n_terms(n_terms), .hold(hold), .abort(abort),
    .Ro(Ro), .term_valid(term_valid), .term_idx(term_idx), .busy(busy),
    .done(done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expected terms: emit current value, stop on out-of-range next value or count end.
  task automatic build_model(input logic [1:0] m, input int a, input int b, input int n);
    int x, y, nxt, t, lim;
    exp_q.delete();
    exp_ovf = 1'b0;
    lim = 1 << BITS;
    if (n == 0) return;
    x = a;
    y = b;
    while (1) begin
      exp_q.push_back(x);
      case (m)
        2'b00:   nxt = y;
        2'b01:   nxt = x + b;
        2'b10:   nxt = 2 * x;
        default: nxt = x - b;
      endcase
      if (nxt >= lim || nxt < 0) begin
        exp_ovf = 1'b1;
        break;
      end
      if (exp_q.size() == n) break;
      t = x + y;
      x = nxt;
      y = t;
    end
  endtask

  task automatic run_seq(input logic [1:0] m, input int a, input int b, input int n,
                         input int hold_pct, input bit noise,
                         output int n_got, output int last_ro);
    int got, cyc;
    bit finished, hold_prev;
    logic [BITS-1:0] prev_ro;
    build_model(m, a, b, n);
    mode = m; seed_a = 8'(a); seed_b = 8'(b); n_terms = 8'(n);
    start = 1'b1; hold = 1'b0; abort = 1'b0;
    got = 0; cyc = 0; finished = 1'b0; hold_prev = 1'b0;
    prev_ro = 8'd0; last_ro = 0;
    while (!finished && cyc < 400) begin
      tick();
      cyc++;
      if (term_valid === 1'b1) begin
        checks++;
        if (got >= exp_q.size()) begin
          failures++;
          $display("FAIL extra_term: Ro=%0d idx=%0d, expected only %0d terms", Ro, term_idx, exp_q.size());
        end else if (Ro !== 8'(exp_q[got]) || term_idx !== 8'(got)) begin
          failures++;
          $display("FAIL term: Ro=%0d idx=%0d, expected Ro=%0d idx=%0d", Ro, term_idx, exp_q[got], got);
        end
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || ovf !== 1'b0) begin
          failures++;
          $display("FAIL run_flags: done=%b busy=%b ovf=%b, expected 0/1/0", done, busy, ovf);
        end
        prev_ro = Ro;
        last_ro = int'(Ro);
        got++;
      end else if (done === 1'b1) begin
        finished = 1'b1;
        checks++;
        if (got != exp_q.size()) begin
          failures++;
          $display("FAIL term_count: got %0d terms, expected %0d", got, exp_q.size());
        end
        checks++;
        if (ovf !== exp_ovf || busy !== 1'b1) begin
          failures++;
          $display("FAIL end_flags: ovf=%b busy=%b, expected ovf=%b busy=1", ovf, busy, exp_ovf);
        end
      end else begin
        checks++;
        if (!hold_prev || busy !== 1'b1 || Ro !== prev_ro) begin
          failures++;
          $display("FAIL stall: hold_prev=%b busy=%b Ro=%0d, expected hold_prev=1 busy=1 Ro=%0d", hold_prev, busy, Ro, prev_ro);
        end
      end
      if (finished) begin
        start = 1'b0;
        hold  = 1'b0;
      end else begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        hold  = (int'($urandom_range(0, 99)) < hold_pct) ? 1'b1 : 1'b0;
      end
      mode    = 2'($urandom_range(0, 3));
      seed_a  = 8'($urandom_range(0, 255));
      seed_b  = 8'($urandom_range(0, 255));
      n_terms = 8'($urandom_range(0, 255));
      hold_prev = hold;
    end
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL timeout: no done after %0d cycles, expected done", cyc);
    end else begin
      tick();
      if (busy !== 1'b0 || done !== 1'b0 || term_valid !== 1'b0) begin
        failures++;
        $display("FAIL idle_return: busy=%b done=%b tv=%b, expected 0/0/0", busy, done, term_valid);
      end
    end
    n_got = got;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; hold = 1'b1; abort = 1'b1;
    mode = 2'b00; seed_a = 8'd7; seed_b = 8'd9; n_terms = 8'd4;
    tick(); tick();
    checks++;
    if (Ro !== 8'd0 || term_idx !== 8'd0 || term_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset: Ro=%0d idx=%0d tv=%b busy=%b done=%b ovf=%b, expected all 0", Ro, term_idx, term_valid, busy, done, ovf);
    end
    rst = 1'b0; start = 1'b0; hold = 1'b0; abort = 1'b0;
    tick();
  endtask

  task automatic test_spec_vectors;
    int got, last;
    run_seq(2'b00, 0, 1, 20, 0, 1'b0, got, last);
    checks++;
    if (got != 14 || last != 233 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL fib20: terms=%0d last=%0d ovf=%b, expected 14/233/1", got, last, ovf);
    end
    run_seq(2'b00, 0, 1, 5, 0, 1'b0, got, last);
    checks++;
    if (got != 5 || last != 3 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL fib5: terms=%0d last=%0d ovf=%b, expected 5/3/0", got, last, ovf);
    end
    run_seq(2'b01, 250, 3, 10, 0, 1'b0, got, last);
    checks++;
    if (got != 2 || last != 253 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL arith: terms=%0d last=%0d ovf=%b, expected 2/253/1", got, last, ovf);
    end
    run_seq(2'b11, 10, 4, 10, 0, 1'b0, got, last);
    checks++;
    if (got != 3 || last != 2 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL countdown: terms=%0d last=%0d ovf=%b, expected 3/2/1", got, last, ovf);
    end
    run_seq(2'b10, 3, 0, 10, 0, 1'b0, got, last);
    checks++;
    if (got != 7 || last != 192 || ovf !== 1'b1) begin
      failures++;
      $display("FAIL doubling: terms=%0d last=%0d ovf=%b, expected 7/192/1", got, last, ovf);
    end
  endtask

  task automatic test_hold;
    mode = 2'b00; seed_a = 8'd0; seed_b = 8'd1; n_terms = 8'd20; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    checks++;
    if (term_valid !== 1'b1 || term_idx !== 8'd2 || Ro !== 8'd1) begin
      failures++;
      $display("FAIL hold_pre: tv=%b idx=%0d Ro=%0d, expected 1/2/1", term_valid, term_idx, Ro);
    end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (term_valid !== 1'b0 || term_idx !== 8'd2 || Ro !== 8'd1 || busy !== 1'b1) begin
        failures++;
        $display("FAIL hold_stall: cycle %0d tv=%b idx=%0d Ro=%0d busy=%b, expected 0/2/1/1", i, term_valid, term_idx, Ro, busy);
      end
    end
    hold = 1'b0;
    tick();
    checks++;
    if (term_valid !== 1'b1 || term_idx !== 8'd3 || Ro !== 8'd2) begin
      failures++;
      $display("FAIL hold_resume: tv=%b idx=%0d Ro=%0d, expected 1/3/2", term_valid, term_idx, Ro);
    end
    abort = 1'b1; tick(); abort = 1'b0; tick();
  endtask

  task automatic test_abort;
    mode = 2'b00; seed_a = 8'd0; seed_b = 8'd1; n_terms = 8'd20; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (term_idx !== 8'd4 || Ro !== 8'd3) begin
      failures++;
      $display("FAIL abort_pre: idx=%0d Ro=%0d, expected 4/3", term_idx, Ro);
    end
    abort = 1'b1; hold = 1'b1;
    tick();
    abort = 1'b0; hold = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || term_valid !== 1'b0 || ovf !== 1'b0 || Ro !== 8'd3) begin
      failures++;
      $display("FAIL abort: busy=%b done=%b tv=%b ovf=%b Ro=%0d, expected 0/0/0/0/3", busy, done, term_valid, ovf, Ro);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_after: done=%b busy=%b, expected 0/0", done, busy);
    end
  endtask

  task automatic test_reset_mid_run;
    mode = 2'b00; seed_a = 8'd0; seed_b = 8'd1; n_terms = 8'd20; start = 1'b1;
    tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (Ro !== 8'd0 || term_idx !== 8'd0 || term_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: Ro=%0d idx=%0d tv=%b busy=%b done=%b ovf=%b, expected all 0", Ro, term_idx, term_valid, busy, done, ovf);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_after: done=%b busy=%b, expected 0/0", done, busy);
    end
  endtask

  task automatic test_zero_terms;
    int got, last;
    run_seq(2'b01, 5, 5, 0, 0, 1'b0, got, last);
    checks++;
    if (got != 0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL zero_terms: terms=%0d ovf=%b, expected 0/0", got, ovf);
    end
  endtask

  task automatic test_start_ignored;
    int got, last;
    run_seq(2'b00, 0, 1, 20, 0, 1'b1, got, last);
    checks++;
    if (got != 14 || last != 233) begin
      failures++;
      $display("FAIL start_in_run: terms=%0d last=%0d, expected 14/233", got, last);
    end
    mode = 2'b01; seed_a = 8'd1; seed_b = 8'd1; n_terms = 8'd2; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL done_pos: done=%b, expected 1", done);
    end
    start = 1'b1; n_terms = 8'd5;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || term_valid !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL start_in_done: busy=%b tv=%b done=%b, expected 0/0/0", busy, term_valid, done);
    end
    tick();
  endtask

  task automatic test_random;
    int got, last;
    for (int r = 0; r < 40; r++) begin
      run_seq(2'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
              int'($urandom_range(0, (r % 2 == 0) ? 255 : 8)),
              int'($urandom_range(0, 20)), 25, 1'b1, got, last);
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_hold();
    test_abort();
    test_reset_mid_run();
    test_zero_terms();
    test_start_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_executor.md
SEQUENCE_EXECUTOR -- requirements
Module: sequence_executor

Interface
REQ-001 BITS, default 8: data width of seeds, registers and Ro.
REQ-002 CNT_W, default 8: width of the term count and term index.
REQ-003 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  run request, sampled in IDLE only.
REQ-006 mode  input  2  sequence mode: 00 fibonacci, 01 arithmetic (+step), 10 doubling, 11 countdown (-step); latched on start.
REQ-007 seed_a  input  BITS  first term; latched on start.
REQ-008 seed_b  input  BITS  second fibonacci term or step; latched on start, ignored in doubling.
REQ-009 n_terms  input  CNT_W  maximum terms to emit; latched on start.
REQ-010 hold  input  1  stall; RUN state and all registers SHALL freeze while high.
REQ-011 abort  input  1  cancel run; returns to IDLE without done.
REQ-012 Ro  output  BITS  current term; registered.
REQ-013 term_valid  output  1  high for each cycle Ro carries a new term.
REQ-014 term_idx  output  CNT_W  index of the term on Ro, starting at 0.
REQ-015 busy  output  1  high in RUN and DONE.
REQ-016 done  output  1  one-cycle pulse when a run ends normally or by overflow.
REQ-017 ovf  output  1  sticky: run ended on carry/borrow; cleared on next accepted start.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on last term or overflow, DONE->IDLE unconditionally after one cycle.
REQ-019 Internal RA (BITS) and RB (BITS+1, carry bit included) SHALL load seed_a and seed_b on the start cycle.
REQ-020 Each non-held RUN cycle SHALL drive Ro=RA, term_valid=1, term_idx=count, then advance: fib RA<=RB, RB<=RA+RB; arith RA<=RA+RB; doubling RA<=RA+RA; countdown RA<=RA-RB.
REQ-021 First term_valid SHALL occur in the cycle after start is sampled; one term per non-held cycle thereafter.
REQ-022 Overflow: if the value that would be emitted next has carry (fib: RB carry; arith/doubling: sum carry-out; countdown: borrow), the FSM SHALL go to DONE after the current term and set ovf.
REQ-023 Run SHALL go to DONE after term index n_terms-1 is emitted; if both count end and overflow coincide, ovf SHALL still be set.
REQ-024 n_terms=0 SHALL produce no term_valid; done pulses the cycle after start, ovf=0.
REQ-025 done SHALL assert in the DONE cycle, i.e. the cycle after the last term_valid; term_valid SHALL be 0 in DONE and IDLE.
REQ-026 start while busy SHALL be ignored; start in the DONE cycle SHALL be ignored.
REQ-027 abort has priority over hold and over overflow/count end: next cycle IDLE, no done, ovf unchanged.
REQ-028 hold during RUN SHALL drop term_valid and keep Ro, term_idx and all state; hold has no effect in IDLE or DONE.
REQ-029 Ro and term_idx SHALL hold their last values in IDLE/DONE.

Reset
REQ-030 While rst is high at a clock edge: state IDLE, RA, RB, Ro, term_idx, count = 0; term_valid, busy, done, ovf = 0.
REQ-031 rst SHALL override start, hold and abort; reset mid-run SHALL discard the run with no done pulse.

Structure
REQ-032 Package seq_exec_pkg SHALL hold the mode enum (MODE_FIB, MODE_ARITH, MODE_DBL, MODE_DOWN) and the state enum.
REQ-033 Sub-module seq_exec_alu (combinational) SHALL compute next RA/RB and the carry/borrow flag from mode, RA, RB.

Verification
REQ-034 BITS=8, fib, seeds 0/1, n_terms=20 -> Ro 0,1,1,2,3,5,8,13,21,34,55,89,144,233 (idx 0..13), then done with ovf=1.
REQ-035 fib, seeds 0/1, n_terms=5 -> 0,1,1,2,3, done the next cycle, ovf=0.
REQ-036 arith, seed_a=250, step 3, n_terms=10 -> 250,253, done, ovf=1; countdown seed 10 step 4 -> 10,6,2, ovf=1.
REQ-037 fib 0/1 with hold high for 3 cycles after idx 2 -> term_valid low 3 cycles, Ro stays 1, resumes with 2 at idx 3.
REQ-038 abort at idx 4 -> IDLE next cycle, no done; rst at idx 4 -> all outputs 0, no done.
REQ-039 n_terms=0 -> no term_valid, done one cycle after start; start pulsed during RUN -> ignored, sequence unchanged.
